// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared types and helpers for the reset release sequencer
//
// Purpose : FSM state enum and the reset-level helper used by rst_release_seq.
// Ports   : none (package).

package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_REL      = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  // Output level of a reset line: asserted=1 gives the "in reset" level,
  // asserted=0 the "released" level, for the chosen polarity.
  function automatic logic res_level(input logic active_high, input logic asserted);
    return asserted ? active_high : ~active_high;
  endfunction

  // Polarity decode from the OUT_RES_POL string.
  function automatic logic pol_is_high(input string pol);
    return (pol == "ACTIVE_HIGH");
  endfunction

endpackage

// File: rtl/rst_seq_dly_cnt.sv
// rtl/rst_seq_dly_cnt.sv - shared delay / acknowledge-timeout counter
//
// Purpose : up-counter with clear, enable and terminal compare. Used both for
//           the inter-stage delay and for the acknowledge timeout.
// Ports   : clk_i   clock (rising edge)
//           rst_i   asynchronous active-low reset
//           clr_i   restart the count; with en_i also set, the count restarts
//                   at 1 so the clearing cycle is itself counted
//           en_i    count enable
//           term_i  terminal value
//           hit_o   count equals term_i

module rst_seq_dly_cnt #(
  parameter int DLY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DLY_W-1:0] term_i,
  output logic             hit_o
);

  logic [DLY_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= DLY_W'(en_i);
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/rst_release_seq.sv
// rtl/rst_release_seq.sv - staged reset release sequencer with per-stage acknowledge
//
// Purpose : releases NUM_STAGES resets one at a time, STAGE_DLY cycles apart,
//           waiting for each stage's acknowledge before the next one.
// Macro   : RST_SEQ_ACK_TIMEOUT_EN - enables the acknowledge timeout and the
//           FAULT state; when undefined err_o is tied to 0.
// Ports   : clk_i     clock (rising edge)
//           rst_i     asynchronous active-low reset
//           sw_rst_i  synchronous soft-reset request, level, active high
//           ack_i     per-stage "out of reset" acknowledge
//           rst_o     per-stage reset, polarity OUT_RES_POL, registered
//           stage_o   number of released stages
//           busy_o    sequence in progress
//           done_o    all stages released and acknowledged
//           err_o     sticky acknowledge timeout flag

module rst_release_seq
  import rst_seq_pkg::*;
#(
  parameter int    NUM_STAGES  = 4,
  parameter int    STAGE_DLY   = 16,
  parameter int    DLY_W       = 8,
  parameter int    ACK_TO      = 255,
  parameter string OUT_RES_POL = "ACTIVE_LOW",
  localparam int   STG_W       = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sw_rst_i,
  input  logic [NUM_STAGES-1:0] ack_i,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic [STG_W-1:0]      stage_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic             ACT_HIGH   = pol_is_high(OUT_RES_POL);
  localparam logic             LVL_ON     = res_level(ACT_HIGH, 1'b1);
  localparam logic             LVL_OFF    = res_level(ACT_HIGH, 1'b0);
  localparam logic [DLY_W-1:0] STAGE_TERM = DLY_W'(STAGE_DLY - 1);
  localparam logic [DLY_W-1:0] ACK_TERM   = DLY_W'(ACK_TO - 1);
  localparam logic [STG_W-1:0] LAST_STG   = STG_W'(NUM_STAGES);

  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_num_stages
    $fatal(1, "rst_release_seq: NUM_STAGES must be in 1..16");
  end
  if (DLY_W < 1 || DLY_W > 30) begin : g_bad_dly_w
    $fatal(1, "rst_release_seq: DLY_W must be in 1..30");
  end
  if (STAGE_DLY < 1 || STAGE_DLY > (1 << DLY_W) - 1) begin : g_bad_stage_dly
    $fatal(1, "rst_release_seq: STAGE_DLY must be in 1..2^DLY_W-1");
  end
  if (ACK_TO < 1 || ACK_TO > (1 << DLY_W) - 1) begin : g_bad_ack_to
    $fatal(1, "rst_release_seq: ACK_TO must be in 1..2^DLY_W-1");
  end
  if (OUT_RES_POL != "ACTIVE_LOW" && OUT_RES_POL != "ACTIVE_HIGH") begin : g_bad_pol
    $fatal(1, "rst_release_seq: OUT_RES_POL must be ACTIVE_LOW or ACTIVE_HIGH");
  end

  state_e                  state_q, state_d;
  logic [STG_W-1:0]        stage_q, stage_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    cnt_clr, cnt_en, cnt_hit;
  logic [DLY_W-1:0]        cnt_term;
  logic                    ack_cur;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
  logic                    err_q, err_d;
`endif

  rst_seq_dly_cnt #(
    .DLY_W (DLY_W)
  ) u_dly_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .hit_o  (cnt_hit)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_HOLD;
      stage_q <= '0;
      rst_q   <= {NUM_STAGES{LVL_ON}};
`ifdef RST_SEQ_ACK_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  // Acknowledge of the most recently released stage (index stage_q-1); all
  // other ack bits are ignored.
  always_comb begin
    ack_cur = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (int'(stage_q) == k + 1) ack_cur = ack_i[k];
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    rst_d    = rst_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_term = (state_q == ST_WAIT_ACK) ? ACK_TERM : STAGE_TERM;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
    err_d    = err_q;
`endif

    if (sw_rst_i) begin
      // Soft reset overrides everything, including a same-cycle acknowledge.
      state_d = ST_HOLD;
      stage_d = '0;
      rst_d   = {NUM_STAGES{LVL_ON}};
      cnt_clr = 1'b1;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
      err_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_HOLD: begin
          cnt_en = 1'b1;
          if (cnt_hit) state_d = ST_REL;
        end

        ST_REL: begin
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (int'(stage_q) == k) rst_d[k] = LVL_OFF;
          end
          stage_d = stage_q + 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (ack_cur) begin
            // The sampling cycle is the first cycle of the next stage delay,
            // so the counter restarts at 1 rather than 0.
            cnt_clr = 1'b1;
            cnt_en  = 1'b1;
            if (stage_q == LAST_STG) begin
              state_d = ST_RUN;
            end else if (STAGE_DLY == 1) begin
              state_d = ST_REL;
            end else begin
              state_d = ST_HOLD;
            end
          end
`ifdef RST_SEQ_ACK_TIMEOUT_EN
          else begin
            cnt_en = 1'b1;
            if (cnt_hit) begin
              state_d = ST_FAULT;
              stage_d = '0;
              rst_d   = {NUM_STAGES{LVL_ON}};
              err_d   = 1'b1;
            end
          end
`endif
        end

        ST_RUN: begin
          // Released resets stay released; ack_i is no longer looked at.
        end

        ST_FAULT: begin
          // Left only through sw_rst_i or rst_i.
        end

        default: begin
          state_d = ST_HOLD;
          stage_d = '0;
          rst_d   = {NUM_STAGES{LVL_ON}};
        end
      endcase
    end
  end

  assign rst_o   = rst_q;
  assign stage_o = stage_q;
  assign busy_o  = (state_q == ST_HOLD) || (state_q == ST_REL) || (state_q == ST_WAIT_ACK);
  assign done_o  = (state_q == ST_RUN);
`ifdef RST_SEQ_ACK_TIMEOUT_EN
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// tb/tb_rst_release_seq.sv - self-checking bench for rst_release_seq

module tb_rst_release_seq;

  localparam int N   = 4;
  localparam int DLY = 16;
  localparam int ATO = 255;
`ifdef RST_SEQ_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic [3:0] ack;
  logic [3:0] rst_o;
  logic [2:0] stage_o;
  logic       busy_o, done_o, err_o;
  logic [0:0] hi_rst, hi_stage;
  logic       hi_busy, hi_done, hi_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: edge-numbered view of the release schedule.
  int m_n, m_stage, m_due, m_rel;
  bit m_wait, m_done, m_fault;

  always #5 clk = ~clk;

  rst_release_seq #(
    .NUM_STAGES (N),
    .STAGE_DLY  (DLY),
    .DLY_W      (8),
    .ACK_TO     (ATO),
    .OUT_RES_POL("ACTIVE_LOW")
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sw_rst_i(sw),
    .ack_i   (ack),
    .rst_o   (rst_o),
    .stage_o (stage_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  rst_release_seq #(
    .NUM_STAGES (1),
    .STAGE_DLY  (1),
    .DLY_W      (8),
    .ACK_TO     (ATO),
    .OUT_RES_POL("ACTIVE_HIGH")
  ) dut_hi (
    .clk_i   (clk),
    .rst_i   (rst),
    .sw_rst_i(1'b0),
    .ack_i   (1'b1),
    .rst_o   (hi_rst),
    .stage_o (hi_stage),
    .busy_o  (hi_busy),
    .done_o  (hi_done),
    .err_o   (hi_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n     = 0;
    m_stage = 0;
    m_due   = DLY + 1;
    m_rel   = 0;
    m_wait  = 0;
    m_done  = 0;
    m_fault = 0;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic [3:0] a);
    if (!r) begin
      model_reset();
      return;
    end
    m_n++;
    if (s) begin
      m_stage = 0;
      m_due   = m_n + DLY + 1;
      m_wait  = 0;
      m_done  = 0;
      m_fault = 0;
    end else if (m_done || m_fault) begin
    end else if (m_wait) begin
      if (a[m_stage-1]) begin
        if (m_stage == N) m_done = 1;
        else begin
          m_wait = 0;
          m_due  = m_n + DLY;
        end
      end else if (TO_EN && (m_n - m_rel == ATO)) begin
        m_fault = 1;
        m_stage = 0;
      end
    end else if (m_n == m_due) begin
      m_stage++;
      m_wait = 1;
      m_rel  = m_n;
    end
  endtask

  task automatic compare_model();
    logic [3:0] e;
    e = '0;
    for (int k = 0; k < N; k++) e[k] = (k < m_stage);
    check("model_rst_o", rst_o, e);
    check("model_stage", stage_o, m_stage);
    check("model_busy", busy_o, !(m_done || m_fault));
    check("model_done", done_o, m_done);
    check("model_err", err_o, TO_EN && m_fault);
  endtask

  task automatic tick();
    logic       r;
    logic       s;
    logic [3:0] a;
    r = rst;
    s = sw;
    a = ack;
    @(posedge clk);
    model_edge(r, s, a);
    #1;
    compare_model();
  endtask

  typedef struct {
    int         edge_n;
    logic [3:0] exp_rst;
    logic [2:0] exp_stage;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_hi;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int w;

    tbl[0] = '{1,  4'b0000, 3'd0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{2,  4'b0000, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{17, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{33, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{34, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{51, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{68, 4'b1111, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{69, 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    sw  = 1'b0;
    ack = 4'h0;
    model_reset();
    repeat (3) tick();
    check("reset_rst_o", rst_o, 4'b0000);
    check("reset_stage", stage_o, 0);
    check("reset_busy", busy_o, 1);
    check("reset_done", done_o, 0);
    check("reset_err", err_o, 0);
    check("reset_hi_rst", hi_rst, 1);

    // Nominal release schedule with all acknowledges high.
    ack = 4'hf;
    rst = 1'b1;
    e   = 0;
    for (int i = 0; i < 9; i++) begin
      while (e < tbl[i].edge_n) begin
        tick();
        e++;
      end
      check($sformatf("tbl%0d_rst_o", i), rst_o, tbl[i].exp_rst);
      check($sformatf("tbl%0d_stage", i), stage_o, tbl[i].exp_stage);
      check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].exp_busy);
      check($sformatf("tbl%0d_done", i), done_o, tbl[i].exp_done);
      check($sformatf("tbl%0d_hi_rst", i), hi_rst, tbl[i].exp_hi);
    end

    // Loss of ack in RUN must not re-assert anything.
    ack = 4'h0;
    repeat (5) tick();
    check("run_ack_lost_rst_o", rst_o, 4'hf);
    check("run_ack_lost_done", done_o, 1);

    // Soft reset from RUN, same cycle as an ack.
    ack = 4'hf;
    sw  = 1'b1;
    tick();
    check("sw_rst_o", rst_o, 4'h0);
    check("sw_stage", stage_o, 0);
    check("sw_busy", busy_o, 1);
    sw = 1'b0;

    // Stall on ack_i[1]; other bits high must not help.
    ack = 4'b1101;
    w   = 0;
    while (stage_o != 3'd2 && w < 80) begin
      tick();
      w++;
    end
    check("stall_reach_stage2", stage_o, 2);
    repeat (100) tick();
    check("stall_rst_o", rst_o, 4'b0011);
    ack = 4'hf;
    w   = 0;
    while (rst_o[2] !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("stall_release_delay", w, 17);
    w = 0;
    while (done_o !== 1'b1 && w < 60) begin
      tick();
      w++;
    end
    check("stall_then_done", done_o, 1);

    // Asynchronous reset while waiting for stage 2's acknowledge.
    sw = 1'b1;
    tick();
    sw  = 1'b0;
    ack = 4'b0001;
    w   = 0;
    while (stage_o != 3'd2 && w < 80) begin
      tick();
      w++;
    end
    repeat (3) tick();
    check("async_pre_stage", stage_o, 2);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_o", rst_o, 4'h0);
    check("async_stage", stage_o, 0);
    check("async_busy", busy_o, 1);
    check("async_done", done_o, 0);
    check("async_err", err_o, 0);
    repeat (2) tick();

`ifdef RST_SEQ_ACK_TIMEOUT_EN
    // Stage 0 never acknowledges: release at edge 17, fault at 17+255.
    ack = 4'h0;
    rst = 1'b1;
    repeat (271) tick();
    check("to_before_err", err_o, 0);
    tick();
    check("to_err", err_o, 1);
    check("to_rst_o", rst_o, 4'h0);
    check("to_busy", busy_o, 0);
    ack = 4'hf;
    repeat (5) tick();
    check("to_sticky_err", err_o, 1);
    sw = 1'b1;
    tick();
    check("to_sw_clear_err", err_o, 0);
    sw = 1'b0;
`else
    rst = 1'b1;
`endif

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      ack = 4'($urandom_range(0, 15));
      sw  = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rst_release_seq.md
RST_RELEASE_SEQ -- requirements
Module: rst_release_seq

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of sequenced reset outputs (1..16).
REQ-002 Parameter STAGE_DLY, default 16: cycles between stage events (1..2^DLY_W-1).
REQ-003 Parameter DLY_W, default 8: delay and timeout counter width.
REQ-004 Parameter ACK_TO, default 255: acknowledge timeout in cycles (1..2^DLY_W-1).
REQ-005 Parameter OUT_RES_POL, default "ACTIVE_LOW": active level of rst_o ("ACTIVE_LOW" or "ACTIVE_HIGH").
REQ-006 clk_i  in  1  the single clock; all logic uses its rising edge.
REQ-007 rst_i  in  1  asynchronous, active-low reset; synchronized deassertion is supplied by the upstream reset bridge.
REQ-008 sw_rst_i  in  1  synchronous soft-reset request, level-sensitive, active high.
REQ-009 ack_i  in  NUM_STAGES  per-stage "out of reset" acknowledge, synchronous to clk_i.
REQ-010 rst_o  out  NUM_STAGES  per-stage reset, polarity per OUT_RES_POL, registered.
REQ-011 stage_o  out  $clog2(NUM_STAGES+1)  count of released stages.
REQ-012 busy_o  out  1  sequence in progress; done_o  out  1  all stages released and acknowledged.
REQ-013 err_o  out  1  acknowledge timeout flag.

Function
REQ-014 The FSM SHALL have the states HOLD, REL, WAIT_ACK, RUN and FAULT.
REQ-015 HOLD: all rst_o asserted; the counter increments each cycle; at count STAGE_DLY-1 the FSM goes to REL.
REQ-016 REL: rst_o[stage_o] deasserts on this edge and stage_o increments; the counter clears; the FSM goes to WAIT_ACK.
REQ-017 WAIT_ACK: sample ack_i[stage_o-1]; when 1, go to RUN if stage_o==NUM_STAGES, otherwise to HOLD.
REQ-018 rst_o[0] SHALL deassert on the (STAGE_DLY+1)-th rising edge after rst_i goes high; each later stage deasserts STAGE_DLY+1 edges after the prior acknowledge is sampled.
REQ-019 Released stages SHALL stay released until sw_rst_i or rst_i; rst_o[k] is never released before rst_o[k-1].
REQ-020 RUN: done_o=1 and busy_o=0; ack_i is ignored, and loss of ack SHALL NOT re-assert resets.
REQ-021 sw_rst_i=1 in any state: the next edge asserts all rst_o, clears stage_o, the counter and err_o, and enters HOLD, which is held while sw_rst_i=1.
REQ-022 sw_rst_i and an ack in the same cycle: sw_rst_i wins.
REQ-023 busy_o=1 in HOLD, REL and WAIT_ACK; 0 in RUN and FAULT.
REQ-024 An ack_i bit for a stage other than the current one SHALL be ignored.

Reset
REQ-025 rst_i low asynchronously SHALL force HOLD, all rst_o asserted, stage_o=0, counter=0, busy_o=1, done_o=0 and err_o=0, including mid-sequence.

Configuration
REQ-026 With RST_SEQ_ACK_TIMEOUT_EN defined: WAIT_ACK counts cycles, and after ACK_TO cycles without ack the FSM enters FAULT, with all rst_o asserted and err_o=1 sticky.
REQ-027 FAULT SHALL be exited only by sw_rst_i or rst_i.
REQ-028 Without RST_SEQ_ACK_TIMEOUT_EN: WAIT_ACK waits indefinitely, FAULT is unreachable and err_o is tied to 0.

Structure
REQ-029 Package rst_seq_pkg SHALL hold the FSM state enum and the polarity helper function (asserted/released level from OUT_RES_POL).
REQ-030 Sub-module rst_seq_dly_cnt (clear, enable, terminal-compare, DLY_W wide) SHALL implement the shared delay/timeout counter.
REQ-031 Parameter legality SHALL be checked at elaboration, with an illegal value giving a fatal error.

Verification
REQ-032 NUM_STAGES=4, STAGE_DLY=16, ack_i tied high -> rst_o releases at edges 17/34/51/68 after rst_i rises; done_o=1 after edge 69.
REQ-033 ack_i[1] held low 100 cycles -> rst_o[2] stays asserted; it releases 17 edges after ack_i[1] rises.
REQ-034 sw_rst_i pulsed while in RUN -> all rst_o assert on the next edge, stage_o=0, and the sequence restarts.
REQ-035 rst_i dropped during WAIT_ACK of stage 2 -> all outputs reach reset values without a clock edge.
REQ-036 Macro defined, ACK_TO=255, ack_i[0]=0 -> err_o=1 and all rst_o asserted after 255 WAIT_ACK cycles; sw_rst_i clears it.
REQ-037 OUT_RES_POL="ACTIVE_HIGH", NUM_STAGES=1, STAGE_DLY=1 -> rst_o=1 in reset and 0 on edge 2.
